// File: rtl/clkgen_pkg.sv
// Shared definitions for the clock divider bank: channel FSM encoding and default field width.
package clkgen_pkg;

  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } ch_state_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock channel: shadow/active config, down-counter FSM, rise strobe and period-done flag.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | stopped, div_clk low, shadow config copied straight to active
//  ST_PHASE | low-phase offset countdown before the first rise
//  ST_HIGH  | div_clk high for half+1 input cycles
//  ST_LOW   | div_clk low for half+1 input cycles; period boundary at terminal count
//
// The phase value is consumed only when a channel starts from IDLE or on resync, and both
// of those points apply the shadow first, so the shadow register doubles as the active phase.
module clk_div_channel
  import clkgen_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_HALF = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic             resync,
  input  logic             clr_done,
  input  logic [CNT_W-1:0] half_in,
  input  logic [CNT_W-1:0] phase_in,
  output logic             div_clk,
  output logic             div_en,
  output logic             cfg_pend,
  output logic             done
);

  ch_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_act;
  logic [CNT_W-1:0] half_sh;
  logic [CNT_W-1:0] phase_sh;
  logic [CNT_W-1:0] half_eff;
  logic [CNT_W-1:0] phase_eff;
  logic             apply_now;
  logic             tc;

  // A load in the same cycle as an apply point is used directly (latest wins).
  assign half_eff  = cfg_load ? half_in  : half_sh;
  assign phase_eff = cfg_load ? phase_in : phase_sh;
  assign apply_now = cfg_pend | cfg_load;
  assign tc        = (cnt == '0);

  // Channel FSM, counter, config registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      half_act <= CNT_W'(DEFAULT_HALF);
      half_sh  <= CNT_W'(DEFAULT_HALF);
      phase_sh <= '0;
      div_clk  <= 1'b0;
      div_en   <= 1'b0;
      cfg_pend <= 1'b0;
      done     <= 1'b0;
    end else begin
      div_en <= 1'b0;
      if (cfg_load) begin
        half_sh  <= half_in;
        phase_sh <= phase_in;
      end
      if (resync && enable) begin
        half_act <= half_eff;
        cfg_pend <= 1'b0;
        state    <= ST_PHASE;
        cnt      <= phase_eff;
        div_clk  <= 1'b0;
        done     <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            half_act <= half_eff;
            cfg_pend <= 1'b0;
            done     <= 1'b0;
            div_clk  <= 1'b0;
            if (enable) begin
              state <= ST_PHASE;
              cnt   <= phase_eff;
            end
          end
          ST_PHASE: begin
            if (cfg_load) cfg_pend <= 1'b1;
            if (tc) begin
              if (enable) begin
                state   <= ST_HIGH;
                cnt     <= half_act;
                div_clk <= 1'b1;
                div_en  <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_HIGH: begin
            if (cfg_load) cfg_pend <= 1'b1;
            if (tc) begin
              state   <= ST_LOW;
              cnt     <= half_act;
              div_clk <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_LOW: begin
            if (tc) begin
              if (apply_now) begin
                half_act <= half_eff;
                cfg_pend <= 1'b0;
              end
              if (enable) begin
                state   <= ST_HIGH;
                cnt     <= apply_now ? half_eff : half_act;
                div_clk <= 1'b1;
                div_en  <= 1'b1;
                done    <= ~apply_now;
              end else begin
                state <= ST_IDLE;
                done  <= 1'b0;
              end
            end else begin
              if (cfg_load) cfg_pend <= 1'b1;
              cnt <= cnt - 1'b1;
            end
          end
        endcase
      end
      if (clr_done) done <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independently configured clock dividers sharing load/resync controls.
module clock_divider_bank
  import clkgen_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_HALF = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*CNT_W-1:0] half_cfg,
  input  logic [NUM_CH*CNT_W-1:0] phase_cfg,
  input  logic                    cfg_load,
  input  logic                    resync,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic [NUM_CH-1:0]       div_clk,
  output logic [NUM_CH-1:0]       div_en,
  output logic [NUM_CH-1:0]       cfg_pend,
  output logic                    locked
);

  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] done;
  logic              en_chg;

  // Any enable change restarts the lock qualification on every channel.
  assign en_chg = (ch_enable != en_q);

  // locked is a pure reduction of registered state, so it drops on the same edge
  // that clears a done flag (apply, resync, enable change).
  assign locked = (|en_q) & (&(done | ~en_q));

  // Previous enable vector for change detection and the lock reduction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) en_q <= '0;
    else        en_q <= ch_enable;
  end

  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .enable   (ch_enable[g]),
      .cfg_load (cfg_load),
      .resync   (resync),
      .clr_done (en_chg),
      .half_in  (half_cfg[g*CNT_W +: CNT_W]),
      .phase_in (phase_cfg[g*CNT_W +: CNT_W]),
      .div_clk  (div_clk[g]),
      .div_en   (div_en[g]),
      .cfg_pend (cfg_pend[g]),
      .done     (done[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank with a period-position reference model.
module tb_clock_divider_bank;

  localparam int NCH = 3;
  localparam int CW  = 8;

  logic              clock;
  logic              reset;
  logic [NCH*CW-1:0] half_cfg;
  logic [NCH*CW-1:0] phase_cfg;
  logic              cfg_load;
  logic              resync;
  logic [NCH-1:0]    ch_enable;
  logic [NCH-1:0]    div_clk;
  logic [NCH-1:0]    div_en;
  logic [NCH-1:0]    cfg_pend;
  logic              locked;
  logic [9:0]        dut_vec;

  int errors = 0;
  int checks = 0;

  // Reference model: run 0=stopped, 1=waiting out phase, 2=running (pos = cycles since rise)
  int       m_run [NCH];
  int       m_wait[NCH];
  int       m_pos [NCH];
  int       m_h   [NCH];
  int       m_hs  [NCH];
  int       m_ps  [NCH];
  bit       m_pend[NCH];
  bit       m_done[NCH];
  bit       m_clk [NCH];
  bit       m_den [NCH];
  logic [NCH-1:0] m_en_prev;

  clock_divider_bank #(
    .NUM_CH       (NCH),
    .CNT_W        (CW),
    .DEFAULT_HALF (0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .half_cfg  (half_cfg),
    .phase_cfg (phase_cfg),
    .cfg_load  (cfg_load),
    .resync    (resync),
    .ch_enable (ch_enable),
    .div_clk   (div_clk),
    .div_en    (div_en),
    .cfg_pend  (cfg_pend),
    .locked    (locked)
  );

  assign dut_vec = {div_clk, div_en, cfg_pend, locked};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_wait[i] = 0; m_pos[i] = 0; m_h[i] = 0; m_hs[i] = 0; m_ps[i] = 0;
      m_pend[i] = 0; m_done[i] = 0; m_clk[i] = 0; m_den[i] = 0;
    end
    m_en_prev = '0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] en;
    bit chg;
    int hin, pin, eh, ep;
    bit app;
    en  = ch_enable;
    chg = (en != m_en_prev);
    for (int i = 0; i < NCH; i++) begin
      hin = int'(half_cfg[i*CW +: CW]);
      pin = int'(phase_cfg[i*CW +: CW]);
      eh  = cfg_load ? hin : m_hs[i];
      ep  = cfg_load ? pin : m_ps[i];
      m_den[i] = 0;
      if (cfg_load) begin m_hs[i] = hin; m_ps[i] = pin; end
      if (resync && en[i]) begin
        m_h[i] = eh; m_pend[i] = 0; m_run[i] = 1; m_wait[i] = ep; m_clk[i] = 0; m_done[i] = 0;
      end else begin
        case (m_run[i])
          0: begin
            m_h[i] = eh; m_pend[i] = 0; m_done[i] = 0;
            if (en[i]) begin m_run[i] = 1; m_wait[i] = ep; end
          end
          1: begin
            if (cfg_load) m_pend[i] = 1;
            if (m_wait[i] == 0) begin
              if (en[i]) begin m_run[i] = 2; m_pos[i] = 0; m_clk[i] = 1; m_den[i] = 1; end
              else m_run[i] = 0;
            end else m_wait[i]--;
          end
          default: begin
            if (cfg_load) m_pend[i] = 1;
            m_pos[i]++;
            if (m_pos[i] == 2 * (m_h[i] + 1)) begin
              app = m_pend[i];
              if (app) begin m_h[i] = m_hs[i]; m_pend[i] = 0; end
              m_done[i] = !app;
              if (en[i]) begin m_pos[i] = 0; m_clk[i] = 1; m_den[i] = 1; end
              else begin m_run[i] = 0; m_clk[i] = 0; m_done[i] = 0; end
            end else if (m_pos[i] == m_h[i] + 1) begin
              m_clk[i] = 0;
            end
          end
        endcase
      end
      if (chg) m_done[i] = 0;
    end
    m_en_prev = en;
  endtask

  function automatic logic [9:0] exp_vec();
    logic [NCH-1:0] c, e, p;
    logic l;
    l = |m_en_prev;
    for (int i = 0; i < NCH; i++) begin
      c[i] = m_clk[i]; e[i] = m_den[i]; p[i] = m_pend[i];
      if (m_en_prev[i] && !m_done[i]) l = 1'b0;
    end
    return {c, e, p, l};
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set_cfg(input int h0, input int h1, input int h2,
                         input int p0, input int p1, input int p2);
    half_cfg  = {8'(h2), 8'(h1), 8'(h0)};
    phase_cfg = {8'(p2), 8'(p1), 8'(p0)};
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_load = 1'b0; resync = 1'b0; ch_enable = '0;
    half_cfg = '0; phase_cfg = '0;
    #12;
    checks++;
    if (dut_vec !== 10'b0) begin
      errors++; $display("FAIL reset_values got=%b exp=%b", dut_vec, 10'b0);
    end
    #1 reset = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    int rises[NCH];
    set_cfg(0, 1, 3, 0, 0, 0);
    cfg_load = 1'b1; step(); cfg_load = 1'b0;
    ch_enable = 3'b111; resync = 1'b1; step(); resync = 1'b0;
    for (int i = 0; i < NCH; i++) rises[i] = 0;
    for (int c = 1; c <= 32; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL basic_wave cyc=%0d got=%b exp=%b", c, dut_vec, exp_vec());
      end
      if (c == 1) begin
        checks++;
        if (div_clk !== 3'b111) begin
          errors++; $display("FAIL basic_aligned_rise got=%b exp=111", div_clk);
        end
      end
      for (int i = 0; i < NCH; i++) rises[i] += int'(div_en[i]);
    end
    checks++;
    if (rises[0] != 16 || rises[1] != 8 || rises[2] != 4) begin
      errors++; $display("FAIL basic_rise_count got=%0d/%0d/%0d exp=16/8/4", rises[0], rises[1], rises[2]);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL basic_locked got=%b exp=1", locked);
    end
  endtask

  task automatic test_phase();
    int first[NCH];
    set_cfg(0, 1, 3, 0, 2, 5);
    cfg_load = 1'b1; step(); cfg_load = 1'b0;
    resync = 1'b1; step(); resync = 1'b0;
    checks++;
    if (cfg_pend !== 3'b000 || locked !== 1'b0) begin
      errors++; $display("FAIL phase_resync_clear got pend=%b lock=%b exp pend=000 lock=0", cfg_pend, locked);
    end
    for (int i = 0; i < NCH; i++) first[i] = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL phase_wave cyc=%0d got=%b exp=%b", c, dut_vec, exp_vec());
      end
      for (int i = 0; i < NCH; i++) if (div_en[i] && first[i] < 0) first[i] = c;
    end
    checks++;
    if (first[0] != 1 || first[1] - first[0] != 2 || first[2] - first[0] != 5) begin
      errors++; $display("FAIL phase_offsets got=%0d/%0d/%0d exp=1/3/6", first[0], first[1], first[2]);
    end
  endtask

  task automatic test_midhigh_load();
    logic [15:0] got;
    logic [15:0] exp_pat;
    int n;
    exp_pat = 16'b0011_0011_0000_1111;
    n = 0;
    while (div_en[2] !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (div_en[2] !== 1'b1) begin
      errors++; $display("FAIL midload_wait_rise got=timeout exp=rise within 20");
    end
    got = '0;
    got[0] = div_clk[2];
    set_cfg(0, 1, 1, 0, 2, 5);
    cfg_load = 1'b1;
    for (int k = 1; k < 16; k++) begin
      step();
      cfg_load = 1'b0;
      got[k] = div_clk[2];
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL midload_wave idx=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
      if (k == 1 || k == 7 || k == 8) begin
        checks++;
        if (cfg_pend[2] !== (k != 8)) begin
          errors++; $display("FAIL midload_pend idx=%0d got=%b exp=%b", k, cfg_pend[2], (k != 8));
        end
      end
    end
    checks++;
    if (got !== exp_pat) begin
      errors++; $display("FAIL midload_shape got=%b exp=%b", got, exp_pat);
    end
  endtask

  task automatic test_disable();
    logic [15:0] got;
    int n;
    n = 0;
    while (div_en[1] !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (div_en[1] !== 1'b1) begin
      errors++; $display("FAIL disable_wait_rise got=timeout exp=rise within 20");
    end
    got = '0;
    got[0] = div_clk[1];
    ch_enable = 3'b101;
    for (int k = 1; k < 16; k++) begin
      step();
      got[k] = div_clk[1];
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL disable_wave idx=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
    end
    checks++;
    if (got !== 16'b0000_0000_0000_0011) begin
      errors++; $display("FAIL disable_shape got=%b exp=%b", got, 16'b0000_0000_0000_0011);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL disable_tail cyc=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b1 || div_clk[1] !== 1'b0) begin
      errors++; $display("FAIL disable_lock got lock=%b clk1=%b exp lock=1 clk1=0", locked, div_clk[1]);
    end
  endtask

  task automatic test_load_resync_reset();
    int first[NCH];
    set_cfg(2, 0, 1, 1, 0, 3);
    ch_enable = 3'b111; cfg_load = 1'b1; resync = 1'b1;
    step();
    cfg_load = 1'b0; resync = 1'b0;
    checks++;
    if (cfg_pend !== 3'b000) begin
      errors++; $display("FAIL lr_pend got=%b exp=000", cfg_pend);
    end
    for (int i = 0; i < NCH; i++) first[i] = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL lr_wave cyc=%0d got=%b exp=%b", c, dut_vec, exp_vec());
      end
      for (int i = 0; i < NCH; i++) if (div_en[i] && first[i] < 0) first[i] = c;
    end
    checks++;
    if (first[0] != 2 || first[1] != 1 || first[2] != 4) begin
      errors++; $display("FAIL lr_first_rise got=%0d/%0d/%0d exp=2/1/4", first[0], first[1], first[2]);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 10'b0) begin
      errors++; $display("FAIL reset_async got=%b exp=%b", dut_vec, 10'b0);
    end
    @(posedge clock);
    #2;
    checks++;
    if (dut_vec !== 10'b0) begin
      errors++; $display("FAIL reset_hold got=%b exp=%b", dut_vec, 10'b0);
    end
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 40; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL post_reset_wave cyc=%0d got=%b exp=%b", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_max_half();
    int en_cnt, hi_len;
    bit in_high;
    set_cfg(255, 0, 0, 0, 0, 0);
    ch_enable = 3'b001; cfg_load = 1'b1; resync = 1'b1;
    step();
    cfg_load = 1'b0; resync = 1'b0;
    en_cnt = 0; hi_len = 0; in_high = 1'b1;
    for (int c = 1; c <= 1024; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL maxhalf_wave cyc=%0d got=%b exp=%b", c, dut_vec, exp_vec());
      end
      en_cnt += int'(div_en[0]);
      if (in_high && div_clk[0]) hi_len++;
      else in_high = 1'b0;
    end
    checks++;
    if (en_cnt != 2 || hi_len != 256) begin
      errors++; $display("FAIL maxhalf_shape got en=%0d high=%0d exp en=2 high=256", en_cnt, hi_len);
    end
  endtask

  task automatic test_random();
    int h[NCH], p[NCH];
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) ch_enable = ch_enable ^ (3'b001 << $urandom_range(2));
      cfg_load = ($urandom_range(29) == 0);
      if (cfg_load) begin
        for (int i = 0; i < NCH; i++) begin h[i] = $urandom_range(7); p[i] = $urandom_range(7); end
        set_cfg(h[0], h[1], h[2], p[0], p[1], p[2]);
      end
      resync = ($urandom_range(59) == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_wave cyc=%0d got=%b exp=%b", c, dut_vec, exp_vec());
      end
    end
    cfg_load = 1'b0; resync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_phase();
    test_midhigh_load();
    test_disable();
    test_load_resync_reset();
    test_max_half();
    ch_enable = 3'b111;
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
